// File: rtl/key_cmd_pkg.sv
// rtl/key_cmd_pkg.sv - shared command codes, key codes and FSM states for key_cmd_queue
package key_cmd_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_NONE    = 3'd0;
    localparam cmd_t CMD_UP      = 3'd1;
    localparam cmd_t CMD_DOWN    = 3'd2;
    localparam cmd_t CMD_LEFT    = 3'd3;
    localparam cmd_t CMD_RIGHT   = 3'd4;
    localparam cmd_t CMD_UNDO    = 3'd5;
    localparam cmd_t CMD_RESTART = 3'd6;

    localparam logic [4:0] KEY_UP      = 5'h01;
    localparam logic [4:0] KEY_DOWN    = 5'h05;
    localparam logic [4:0] KEY_LEFT    = 5'h04;
    localparam logic [4:0] KEY_RIGHT   = 5'h06;
    localparam logic [4:0] KEY_UNDO    = 5'h10;
    localparam logic [4:0] KEY_RESTART = 5'h11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_DELAY  = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    // Scanner code to game command; anything unlisted is ignored.
    function automatic cmd_t map_key(input logic [4:0] code);
        cmd_t c;
        case (code)
            KEY_UP:      c = CMD_UP;
            KEY_DOWN:    c = CMD_DOWN;
            KEY_LEFT:    c = CMD_LEFT;
            KEY_RIGHT:   c = CMD_RIGHT;
            KEY_UNDO:    c = CMD_UNDO;
            KEY_RESTART: c = CMD_RESTART;
            default:     c = CMD_NONE;
        endcase
        return c;
    endfunction

    // Only the four directions auto-repeat.
    function automatic logic is_dir(input cmd_t c);
        return (c == CMD_UP) || (c == CMD_DOWN) || (c == CMD_LEFT) || (c == CMD_RIGHT);
    endfunction

endpackage

// File: rtl/key_cmd_fifo.sv
// rtl/key_cmd_fifo.sv - show-ahead command FIFO with overflow pulse and full-with-pop handling
module key_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             overflow_q;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    // A pop on a full FIFO frees the slot the same-cycle push needs.
    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == LVL_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage, pointers, occupancy and the registered drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push && !do_push;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign valid    = !empty;
    assign head     = empty ? '0 : mem_q[rd_ptr_q];
    assign overflow = overflow_q;
    assign level    = level_q;

endmodule

// File: rtl/key_cmd_queue.sv
// rtl/key_cmd_queue.sv - keypad press to game command translator with auto-repeat and FIFO
module key_cmd_queue
    import key_cmd_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4:0]               key_code,
    input  logic                     key_ready,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic [2:0]               cmd,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    cmd_t             rep_cmd_q;
    logic             key_ready_q;
    logic [4:0]       code_q;

    cmd_t             press_cmd;
    logic             press;
    logic             delay_hit;
    logic             period_hit;
    logic             push;
    cmd_t             push_data;
    logic [CNT_W-1:0] cnt_inc;

    // Press detection, mapping and the push request (fresh press wins over a repeat).
    always_comb begin
        press_cmd  = map_key(key_code);
        press      = key_ready && (!key_ready_q || (key_code != code_q));
        delay_hit  = (state_q == ST_DELAY)  && (cnt_q == DELAY_LAST);
        period_hit = (state_q == ST_REPEAT) && (cnt_q == PERIOD_LAST);
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        push       = 1'b0;
        push_data  = CMD_NONE;
        if (press) begin
            push      = (press_cmd != CMD_NONE);
            push_data = press_cmd;
        end else if (key_ready && (delay_hit || period_hit)) begin
            push      = 1'b1;
            push_data = rep_cmd_q;
        end
    end

    // Input history and repeat FSM; a key release always returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_ready_q <= 1'b0;
            code_q      <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rep_cmd_q   <= CMD_NONE;
        end else begin
            key_ready_q <= key_ready;
            code_q      <= key_code;
            if (!key_ready) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else if (press) begin
                cnt_q <= '0;
                if (is_dir(press_cmd)) begin
                    state_q   <= ST_DELAY;
                    rep_cmd_q <= press_cmd;
                end else begin
                    state_q <= ST_HOLD;
                end
            end else begin
                case (state_q)
                    ST_DELAY: begin
                        if (delay_hit) begin
                            state_q <= ST_REPEAT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    ST_REPEAT: begin
                        if (period_hit) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        cnt_q <= cnt_q;
                    end
                endcase
            end
        end
    end

    key_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (cmd_ready),
        .valid     (cmd_valid),
        .head      (cmd),
        .overflow  (overflow),
        .level     (level)
    );

endmodule

// File: tb/tb_key_cmd_queue.sv
// tb/tb_key_cmd_queue.sv - directed self-checking bench for key_cmd_queue
module tb_key_cmd_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] key_code;
    logic       key_ready;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       overflow;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    key_cmd_queue #(
        .DEPTH         (4),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_code  (key_code),
        .key_ready (key_ready),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic v, input logic [2:0] c,
                           input logic [2:0] l, input logic o);
        check({tag, ".valid"}, 32'(cmd_valid), 32'(v));
        check({tag, ".cmd"},   32'(cmd),       32'(c));
        check({tag, ".level"}, 32'(level),     32'(l));
        check({tag, ".ovf"},   32'(overflow),  32'(o));
    endtask

    initial begin
        rst_n     = 1'b0;
        key_code  = 5'h00;
        key_ready = 1'b0;
        cmd_ready = 1'b0;
        step(3);
        check_q("por", 1'b0, 3'd0, 3'd0, 1'b0);
        rst_n = 1'b1;
        step(1);

        // Single LEFT press held 3 cycles: one entry, no repeat.
        key_code = 5'h04; key_ready = 1'b1;
        step(1);
        check_q("single.push", 1'b1, 3'd3, 3'd1, 1'b0);
        step(2);
        check_q("single.hold", 1'b1, 3'd3, 3'd1, 1'b0);
        key_ready = 1'b0;
        step(1);
        cmd_ready = 1'b1;
        step(1);
        check_q("single.pop", 1'b0, 3'd0, 3'd0, 1'b0);
        cmd_ready = 1'b0;

        // Auto-repeat of UP: pushes at E, E+8, E+12, E+16; E+20 overflows.
        key_code = 5'h01; key_ready = 1'b1;
        step(1);
        check_q("rep.e0", 1'b1, 3'd1, 3'd1, 1'b0);
        step(7);
        check("rep.e7.level", 32'(level), 32'd1);
        step(1);
        check_q("rep.e8", 1'b1, 3'd1, 3'd2, 1'b0);
        step(4);
        check_q("rep.e12", 1'b1, 3'd1, 3'd3, 1'b0);
        step(4);
        check_q("rep.e16", 1'b1, 3'd1, 3'd4, 1'b0);
        step(3);
        check_q("rep.e19", 1'b1, 3'd1, 3'd4, 1'b0);
        step(1);
        check_q("rep.e20", 1'b1, 3'd1, 3'd4, 1'b1);
        step(1);
        check_q("rep.e21", 1'b1, 3'd1, 3'd4, 1'b0);
        key_ready = 1'b0;
        cmd_ready = 1'b1;
        step(4);
        check_q("rep.drain", 1'b0, 3'd0, 3'd0, 1'b0);
        cmd_ready = 1'b0;

        // UNDO held 30 cycles: exactly one entry.
        key_code = 5'h10; key_ready = 1'b1;
        step(1);
        check_q("undo.push", 1'b1, 3'd5, 3'd1, 1'b0);
        step(30);
        check_q("undo.hold", 1'b1, 3'd5, 3'd1, 1'b0);
        key_ready = 1'b0;
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        check("undo.pop.level", 32'(level), 32'd0);

        // Unmapped key: nothing pushed, ever.
        key_code = 5'h1F; key_ready = 1'b1;
        step(12);
        check_q("unmapped", 1'b0, 3'd0, 3'd0, 1'b0);
        key_ready = 1'b0;
        step(1);

        // DOWN for 3 cycles then RIGHT while held; repeat timer restarts at change edge E1.
        key_code = 5'h05; key_ready = 1'b1;
        step(1);
        check_q("chg.down", 1'b1, 3'd2, 3'd1, 1'b0);
        step(2);
        key_code = 5'h06;
        step(1);
        check_q("chg.right", 1'b1, 3'd2, 3'd2, 1'b0);
        step(6);
        check("chg.e1p6.level", 32'(level), 32'd2);
        step(1);
        check("chg.e1p7.level", 32'(level), 32'd2);
        step(1);
        check_q("chg.e1p8", 1'b1, 3'd2, 3'd3, 1'b0);
        key_ready = 1'b0;
        cmd_ready = 1'b1;
        step(1);
        check("chg.head2", 32'(cmd), 32'd4);
        step(1);
        check("chg.head3", 32'(cmd), 32'd4);
        step(1);
        check_q("chg.drain", 1'b0, 3'd0, 3'd0, 1'b0);
        cmd_ready = 1'b0;

        // Fill with UP, DOWN, LEFT, RIGHT via code changes.
        key_ready = 1'b1;
        key_code = 5'h01; step(1);
        key_code = 5'h05; step(1);
        key_code = 5'h04; step(1);
        key_code = 5'h06; step(1);
        check_q("full.fill", 1'b1, 3'd1, 3'd4, 1'b0);
        // Press UNDO with a concurrent pop while full.
        key_code = 5'h10; cmd_ready = 1'b1;
        step(1);
        check_q("full.pushpop", 1'b1, 3'd2, 3'd4, 1'b0);
        cmd_ready = 1'b0;
        // Press RESTART while full with no pop: dropped.
        key_code = 5'h11;
        step(1);
        check_q("full.drop", 1'b1, 3'd2, 3'd4, 1'b1);
        key_ready = 1'b0;
        cmd_ready = 1'b1;
        step(1);
        check("full.q1", 32'(cmd), 32'd3);
        check("full.ovf_clear", 32'(overflow), 32'd0);
        step(1);
        check("full.q2", 32'(cmd), 32'd4);
        step(1);
        check("full.q3", 32'(cmd), 32'd5);
        step(1);
        check_q("full.drain", 1'b0, 3'd0, 3'd0, 1'b0);
        // Pop while empty is ignored.
        step(1);
        check("empty.pop.level", 32'(level), 32'd0);
        cmd_ready = 1'b0;

        // Reset with 2 entries and DOWN still held; release with key still down.
        key_ready = 1'b1;
        key_code = 5'h01; step(1);
        key_code = 5'h05; step(1);
        check("rst.pre.level", 32'(level), 32'd2);
        rst_n = 1'b0;
        #1;
        check_q("rst.async", 1'b0, 3'd0, 3'd0, 1'b0);
        step(1);
        check_q("rst.held", 1'b0, 3'd0, 3'd0, 1'b0);
        rst_n = 1'b1;
        step(1);
        check_q("rst.fresh", 1'b1, 3'd2, 3'd1, 1'b0);
        key_ready = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
